// File: rtl/debug_pkg.sv
// Shared opcode, response and harness command encodings for the debug host link.
// Also holds the front-end state type so the harness and front end agree on codes.
package debug_pkg;

  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_STEPI = 8'h02;
  localparam logic [7:0] OP_STEPC = 8'h03;
  localparam logic [7:0] OP_LOAD  = 8'h10;
  localparam logic [7:0] OP_CLEAR = 8'h20;

  localparam logic [7:0] RSP_EXEC    = 8'h40;
  localparam logic [7:0] RSP_ACK     = 8'h06;
  localparam logic [7:0] RSP_NAK     = 8'h15;
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;

  localparam logic [3:0] CMD_IDLE  = 4'd0;
  localparam logic [3:0] CMD_RUN   = 4'd1;
  localparam logic [3:0] CMD_STEPI = 4'd2;
  localparam logic [3:0] CMD_STEPC = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_LEN,
    ST_GET_DATA,
    ST_ISSUE,
    ST_WAIT,
    ST_CLEAR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/debug_host_frontend.sv
// Parses host opcode/data bytes into harness strobes, ROM writes and ROM clear,
// then returns exactly one response byte per packet; every output is registered.
module debug_host_frontend
  import debug_pkg::*;
#(
  parameter int ROM_BYTES   = 32,
  parameter int ROM_ADDR_W  = 12,
  parameter int CMD_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [3:0]            debug_cmd,
  input  logic                  command_complete,
  input  logic                  dut_z,
  output logic [7:0]            code_rom_data_in,
  output logic [ROM_ADDR_W-1:0] code_rom_addr_in,
  output logic                  program_rom_mode,
  output logic                  reset_code_rom_n
);

  localparam int TW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;

  state_t                state, state_d;
  logic                  rx_ready_d, tx_valid_d, prog_d, clr_n_d;
  logic [7:0]            tx_data_d, rom_data_d;
  logic [3:0]            debug_cmd_d;
  logic [ROM_ADDR_W-1:0] rom_addr_d, len, len_d, cnt, cnt_d;
  logic [TW-1:0]         tcnt, tcnt_d;
  logic                  accept;

  assign accept = rx_valid && rx_ready;

  always_comb begin
    state_d     = state;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    debug_cmd_d = CMD_IDLE;
    prog_d      = 1'b0;
    rom_addr_d  = code_rom_addr_in;
    rom_data_d  = code_rom_data_in;
    clr_n_d     = 1'b1;
    len_d       = len;
    cnt_d       = cnt;
    tcnt_d      = tcnt;
    case (state)
      ST_IDLE: if (accept) begin
        case (rx_data)
          OP_RUN:   begin state_d = ST_ISSUE; debug_cmd_d = CMD_RUN;   end
          OP_STEPI: begin state_d = ST_ISSUE; debug_cmd_d = CMD_STEPI; end
          OP_STEPC: begin state_d = ST_ISSUE; debug_cmd_d = CMD_STEPC; end
          OP_LOAD:  state_d = ST_GET_LEN;
          OP_CLEAR: begin state_d = ST_CLEAR; clr_n_d = 1'b0; end
          default:  begin state_d = ST_RESP; tx_data_d = RSP_NAK; tx_valid_d = 1'b1; end
        endcase
      end
      ST_GET_LEN: if (accept) begin
        if (rx_data == 8'd0 || {24'd0, rx_data} > 32'(ROM_BYTES)) begin
          state_d    = ST_RESP;
          tx_data_d  = RSP_NAK;
          tx_valid_d = 1'b1;
        end else begin
          state_d = ST_GET_DATA;
          len_d   = ROM_ADDR_W'(rx_data);
          cnt_d   = '0;
        end
      end
      ST_GET_DATA: if (accept) begin
        prog_d     = 1'b1;
        rom_addr_d = cnt;
        rom_data_d = rx_data;
        cnt_d      = cnt + ROM_ADDR_W'(1);
        // ACK is raised by RESP one cycle later so it trails the last write pulse.
        if (cnt == len - ROM_ADDR_W'(1)) begin
          state_d   = ST_RESP;
          tx_data_d = RSP_ACK;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tcnt_d  = '0;
      end
      ST_WAIT: begin
        if (command_complete) begin
          state_d    = ST_RESP;
          tx_data_d  = RSP_EXEC | {7'd0, dut_z};
          tx_valid_d = 1'b1;
        end else if (tcnt == TW'(CMD_TIMEOUT - 1)) begin
          state_d    = ST_RESP;
          tx_data_d  = RSP_TIMEOUT;
          tx_valid_d = 1'b1;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      ST_CLEAR: begin
        state_d    = ST_RESP;
        tx_data_d  = RSP_ACK;
        tx_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (!tx_valid) begin
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_LEN) || (state_d == ST_GET_DATA);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      rx_ready         <= 1'b0;
      tx_data          <= '0;
      tx_valid         <= 1'b0;
      debug_cmd        <= CMD_IDLE;
      program_rom_mode <= 1'b0;
      code_rom_addr_in <= '0;
      code_rom_data_in <= '0;
      reset_code_rom_n <= 1'b1;
      len              <= '0;
      cnt              <= '0;
      tcnt             <= '0;
    end else begin
      state            <= state_d;
      rx_ready         <= rx_ready_d;
      tx_data          <= tx_data_d;
      tx_valid         <= tx_valid_d;
      debug_cmd        <= debug_cmd_d;
      program_rom_mode <= prog_d;
      code_rom_addr_in <= rom_addr_d;
      code_rom_data_in <= rom_data_d;
      reset_code_rom_n <= clr_n_d;
      len              <= len_d;
      cnt              <= cnt_d;
      tcnt             <= tcnt_d;
    end
  end

endmodule

// File: doc/debug_host_frontend.md
# debug_host_frontend

Byte-stream command front end sitting directly upstream of `debug_harness`. It accepts opcode/data bytes from the host link's receive side, which is the UART RX carrying the Python UI's traffic. It turns those bytes into `debug_harness` control:

- one-cycle `debug_cmd` strobes;
- code-ROM write pulses;
- a ROM clear pulse.

After each harness command it waits for `command_complete` and returns exactly one response byte to the host link's transmit side.

## Interface
Parameters:
- `ROM_BYTES`, default 32: code-ROM size in bytes; must match the harness.
- `ROM_ADDR_W`, default 12: width of the code-ROM byte address.
- `CMD_TIMEOUT`, default 1024: number of cycles to wait for `command_complete` before reporting a timeout.

Ports:
- `clk` in, 1: single clock.
- `reset_n` in, 1: asynchronous, active-low reset.
- `rx_data` in, 8: byte from the host link.
- `rx_valid` in, 1: `rx_data` is valid.
- `rx_ready` out, 1: front end can accept a byte.
- `tx_data` out, 8: response byte.
- `tx_valid` out, 1: response byte is valid.
- `tx_ready` in, 1: host link has taken the byte.
- `debug_cmd` out, 4: command to the harness; 0 = none.
- `command_complete` in, 1: completion flag from the harness.
- `dut_z` in, 1: the harness `Z` output, reported in the response.
- `code_rom_data_in` out, 8: ROM write data.
- `code_rom_addr_in` out, ROM_ADDR_W: ROM write address.
- `program_rom_mode` out, 1: one-cycle ROM write strobe.
- `reset_code_rom_n` out, 1: active-low ROM clear pulse.

## Operation
Opcodes (first byte of each packet):
- 0x01 RUN: issue `debug_cmd` = 1.
- 0x02 STEPI: issue `debug_cmd` = 2.
- 0x03 STEPC: issue `debug_cmd` = 3.
- 0x10 LOAD: next byte is N, followed by N data bytes written to ROM addresses 0..N-1 in order.
- 0x20 CLEAR: pulse `reset_code_rom_n` low.
- Any other opcode: NAK.

Response codes:
- Execute commands (RUN, STEPI, STEPC): 0x40 | `dut_z`, with `dut_z` sampled in the cycle `command_complete` is seen.
- LOAD and CLEAR: ACK 0x06.
- Bad opcode, or N = 0, or N > ROM_BYTES: NAK 0x15.
- Timeout: 0x54.

State machine (IDLE, GET_LEN, GET_DATA, ISSUE, WAIT, CLEAR, RESP):
- IDLE: `rx_ready` = 1. An accepted opcode moves to ISSUE, GET_LEN or CLEAR, or to RESP with NAK.
- GET_LEN: `rx_ready` = 1. A valid N moves to GET_DATA with the byte counter cleared. An invalid N moves to RESP with NAK; no writes occur, and the following bytes are parsed as opcodes.
- GET_DATA: `rx_ready` = 1. Each accepted byte issues a write and increments the address. After byte N, move to RESP with ACK.
- ISSUE: drive `debug_cmd` for exactly one cycle, then go to WAIT. The harness re-samples `debug_cmd` on every IDLE cycle, so the strobe must never be held longer than one cycle.
- WAIT: `debug_cmd` = 0 and the timeout counter runs.
  - `command_complete` = 1 moves to RESP with the status byte.
  - The counter reaching CMD_TIMEOUT-1 moves to RESP with 0x54.
  - If both happen in the same cycle, completion wins.
- CLEAR: `reset_code_rom_n` = 0 for one cycle, then RESP with ACK.
- RESP: `tx_valid` = 1 with `tx_data` held stable until `tx_ready`; then return to IDLE. `rx_ready` = 0 throughout.

Other behaviour:
- Byte accepted = `rx_valid` && `rx_ready`. `rx_ready` is 0 in ISSUE, WAIT, CLEAR and RESP.
- Reset mid-operation abandons the packet. ROM bytes already written keep their contents, because `reset_n` does not clear the ROM.

## Timing
Reset values:
- `rx_ready` = 0 during reset and 1 in the first IDLE cycle after it.
- `tx_valid` = 0, `tx_data` = 0.
- `debug_cmd` = 0.
- `program_rom_mode` = 0, `code_rom_addr_in` = 0, `code_rom_data_in` = 0.
- `reset_code_rom_n` = 1.

Cycle-level behaviour:
- All outputs are registered.
- Execute opcode accepted at cycle t: `debug_cmd` is nonzero at t+1 only; WAIT starts at t+2.
- `command_complete` sampled high at cycle u: `tx_valid` rises at u+1.
- Data byte accepted at t: `program_rom_mode` = 1 at t+1 for exactly one cycle, with address and data valid in the same cycle. Back-to-back bytes produce back-to-back write pulses.
- The ACK after a LOAD follows the last write pulse by one cycle.
- The timeout counter is ceil(log2(CMD_TIMEOUT)) bits wide and is cleared on entry to WAIT.
- The byte counter and address are ROM_ADDR_W bits wide; no wrap is possible because N ≤ ROM_BYTES.

## Structure
- `debug_pkg` holds:
  - opcode constants;
  - response codes;
  - harness command codes (IDLE = 0, RUN = 1, STEPI = 2, STEPC = 3);
  - the state enum typedef.
- `debug_harness` imports the same harness command codes from `debug_pkg`.
- No sub-module. UART RX/TX stay outside the block and connect through the valid/ready ports.

## Test plan
- RUN (0x01) with `command_complete` returned 2 cycles after the strobe and `dut_z` = 1: `debug_cmd` = 1 for exactly one cycle; `tx_data` = 0x41.
- LOAD 0x10, N = 4, bytes AA BB CC DD: four write pulses at addresses 0–3 with data AA–DD, then ACK 0x06. Repeat with `tx_ready` held low 5 cycles: `tx_data` stays stable.
- LOAD with N = 0, and LOAD with N = 33 (ROM_BYTES = 32): NAK 0x15 and no `program_rom_mode` pulse.
- STEPI (0x02) with `command_complete` never asserted: 0x54 after CMD_TIMEOUT cycles. Also assert completion in the timeout cycle: response is the status byte, not 0x54.
- Opcode 0x7F gives NAK. CLEAR (0x20) gives one low cycle on `reset_code_rom_n`, then ACK.
- Assert `reset_n` after 2 of 4 LOAD data bytes: all outputs return to reset values; the next opcode is parsed normally.
